regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 57 +++++
 rtl/regfile.sv | 88 ++++++++
 tb/tb_regfile.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared CPU constants used by the register file and its scoreboard.
// Widths and enable levels live here so every pipeline stage agrees on them.
package regfile_pkg;

    localparam int RegLen     = 32;
    localparam int RegAddrLen = 5;
    localparam int RegNum     = 32;

    localparam logic [RegLen-1:0] ZERO_WORD = '0;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ResetEnable  = 1'b1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits: set on issue, cleared on write-back, busy outputs combinational.
// Updates on the clock edge only when rdy=1; synchronous active-high rst clears every bit.
module regfile_scoreboard #(
    parameter int RegAddrLen = regfile_pkg::RegAddrLen
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  we,
    input  logic [RegAddrLen-1:0] waddr,
    input  logic                  issue_en,
    input  logic [RegAddrLen-1:0] issue_rd,
    input  logic                  re1,
    input  logic [RegAddrLen-1:0] raddr1,
    input  logic                  fwd1,
    input  logic                  re2,
    input  logic [RegAddrLen-1:0] raddr2,
    input  logic                  fwd2,
    output logic                  busy1,
    output logic                  busy2
);
    import regfile_pkg::*;

    logic [RegNum-1:0] busy_q;
    logic [RegNum-1:0] busy_nxt;

    // Set is applied after clear so an issue wins over a same-cycle write-back.
    always_comb begin
        busy_nxt = busy_q;
        if (we != WriteDisable && waddr != '0) begin
            busy_nxt[waddr] = 1'b0;
        end
        if (issue_en && issue_rd != '0) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst == ResetEnable) begin
            busy_q <= '0;
        end else if (rdy) begin
            busy_q <= busy_nxt;
        end
    end

    // A forwarded operand is already available, so it never stalls decode.
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        if (rst != ResetEnable) begin
            busy1 = re1 && busy_q[raddr1] && !fwd1;
            busy2 = re2 && busy_q[raddr2] && !fwd2;
        end
    end

endmodule

// File: rtl/regfile.sv
// 32-entry register file, two combinational read ports, one write-back port; x0 hardwired to zero.
// Writes land on the clock edge (rdy=0 freezes state); REGFILE_BYPASS_EN forwards wdata to same-cycle reads.
module regfile #(
    parameter int RegLen     = regfile_pkg::RegLen,
    parameter int RegAddrLen = regfile_pkg::RegAddrLen
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  we,
    input  logic [RegAddrLen-1:0] waddr,
    input  logic [RegLen-1:0]     wdata,
    input  logic                  re1,
    input  logic [RegAddrLen-1:0] raddr1,
    output logic [RegLen-1:0]     rdata1,
    input  logic                  re2,
    input  logic [RegAddrLen-1:0] raddr2,
    output logic [RegLen-1:0]     rdata2,
    output logic                  busy1,
    output logic                  busy2,
    input  logic                  issue_en,
    input  logic [RegAddrLen-1:0] issue_rd
);
    import regfile_pkg::*;

    localparam logic [RegLen-1:0] Zero = RegLen'(ZERO_WORD);

    logic [RegLen-1:0] regs [RegNum];
    logic              wr_hit;
    logic              fwd1;
    logic              fwd2;

    assign wr_hit = (we == WriteEnable) && (waddr != '0);

`ifdef REGFILE_BYPASS_EN
    assign fwd1 = wr_hit && (waddr == raddr1);
    assign fwd2 = wr_hit && (waddr == raddr2);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    // A write arriving together with rst is dropped along with everything else.
    always_ff @(posedge clk) begin
        if (rst == ResetEnable) begin
            for (int i = 0; i < RegNum; i++) begin
                regs[i] <= Zero;
            end
        end else if (rdy && wr_hit) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = Zero;
        if (rst != ResetEnable && re1 && raddr1 != '0) begin
            rdata1 = fwd1 ? wdata : regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = Zero;
        if (rst != ResetEnable && re2 && raddr2 != '0) begin
            rdata2 = fwd2 ? wdata : regs[raddr2];
        end
    end

    regfile_scoreboard #(
        .RegAddrLen(RegAddrLen)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .we       (we),
        .waddr    (waddr),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .re1      (re1),
        .raddr1   (raddr1),
        .fwd1     (fwd1),
        .re2      (re2),
        .raddr2   (raddr2),
        .fwd2     (fwd2),
        .busy1    (busy1),
        .busy2    (busy2)
    );

endmodule

// File: tb/tb_regfile.sv
// Directed, table-driven bench for regfile: each row is one cycle of inputs plus
// the combinational outputs expected just before that cycle's rising edge.
module tb_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        re1 = 1'b0;
    logic [4:0]  raddr1 = '0;
    logic [31:0] rdata1;
    logic        re2 = 1'b0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] rdata2;
    logic        busy1;
    logic        busy2;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_rd = '0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        rst, rdy, we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic        ie;
        logic [4:0]  ird;
        logic [31:0] e1, e2;
        logic        eb1, eb2;
    } vec_t;

    regfile dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .re1      (re1),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .re2      (re2),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .busy1    (busy1),
        .busy2    (busy2),
        .issue_en (issue_en),
        .issue_rd (issue_rd)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic r, logic y, logic w, logic [4:0] wa, logic [31:0] wd,
                                logic r1, logic [4:0] a1, logic r2, logic [4:0] a2,
                                logic ie, logic [4:0] ird,
                                logic [31:0] e1, logic [31:0] e2, logic eb1, logic eb2);
        vec_t v;
        v.rst = r;  v.rdy = y;  v.we = w;  v.waddr = wa;  v.wdata = wd;
        v.re1 = r1; v.ra1 = a1; v.re2 = r2; v.ra2 = a2;
        v.ie = ie;  v.ird = ird;
        v.e1 = e1;  v.e2 = e2;  v.eb1 = eb1; v.eb2 = eb2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then check before the rising edge.
    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        rst = v.rst; rdy = v.rdy; we = v.we; waddr = v.waddr; wdata = v.wdata;
        re1 = v.re1; raddr1 = v.ra1; re2 = v.re2; raddr2 = v.ra2;
        issue_en = v.ie; issue_rd = v.ird;
        #1;
        chk({tag, " rdata1"}, rdata1, v.e1);
        chk({tag, " rdata2"}, rdata2, v.e2);
        chk({tag, " busy1"}, {31'd0, busy1}, {31'd0, v.eb1});
        chk({tag, " busy2"}, {31'd0, busy2}, {31'd0, v.eb2});
    endtask

    function automatic logic [31:0] pat(int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, b, b, b} ^ 32'hC300_005A;
    endfunction

    initial begin
        vec_t tbl [13];

        //            rst rdy we wa   wdata          re1 a1 re2 a2 ie ird  e1  e2  eb1  eb2
        tbl[0]  = mk(1, 1, 1, 5, 32'hFFFF0000, 1, 5, 1, 5, 1, 5, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 5, 32'hDEADBEEF, 0, 5, 0, 5, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 1, 0, 32'hFFFFFFFF, 1, 5, 1, 5, 0, 0,
                     32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        tbl[3]  = mk(0, 1, 0, 0, 0, 1, 5, 1, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 1, 7, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 1, 7, 32'h77, 1, 7, 0, 7, 0, 0,
                     BYP ? 32'h77 : 32'h0, 0, !BYP, 0);
        tbl[6]  = mk(0, 1, 1, 7, 32'h78, 1, 7, 0, 0, 1, 7,
                     BYP ? 32'h78 : 32'h77, 0, 0, 0);
        tbl[7]  = mk(0, 1, 0, 0, 0, 1, 7, 0, 0, 0, 0, 32'h78, 0, 1, 0);
        tbl[8]  = mk(0, 1, 1, 7, 32'h79, 0, 7, 1, 7, 0, 0,
                     0, BYP ? 32'h79 : 32'h78, 0, !BYP);
        tbl[9]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 32'h79, 0, 0);
        tbl[10] = mk(0, 1, 1, 3, 32'h12345678, 1, 3, 0, 0, 0, 0,
                     BYP ? 32'h12345678 : 32'h0, 0, 0, 0);
        tbl[11] = mk(0, 0, 1, 4, 32'hA5, 1, 3, 1, 4, 1, 4,
                     32'h12345678, BYP ? 32'hA5 : 32'h0, 0, 0);
        tbl[12] = mk(0, 1, 0, 0, 0, 1, 3, 1, 4, 0, 0, 32'h12345678, 0, 0, 0);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i], $sformatf("row%0d", i));
        end

        // Reset in the middle of live state: pending write and busy bit are both lost.
        step(mk(0, 1, 1, 9, 32'h55, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0), "rst_a");
        step(mk(0, 1, 0, 0, 0, 1, 9, 1, 3, 0, 0, 32'h55, 32'h12345678, 1, 0), "rst_b");
        step(mk(1, 1, 1, 9, 32'hFF, 1, 9, 1, 3, 1, 9, 0, 0, 0, 0), "rst_c");
        step(mk(0, 1, 0, 0, 0, 1, 9, 1, 3, 0, 0, 0, 0, 0, 0), "rst_d");

        // Fill every writable register, then read each back through both ports.
        for (int i = 1; i < 32; i++) begin
            step(mk(0, 1, 1, 5'(i), pat(i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                 $sformatf("fill%0d", i));
        end
        for (int i = 1; i < 32; i++) begin
            step(mk(0, 1, 0, 0, 0, 1, 5'(i), 1, 5'(32 - i), 0, 0,
                    pat(i), pat(32 - i), 0, 0),
                 $sformatf("read%0d", i));
        end
        step(mk(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), "x0_after_fill");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
